pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits (1..256).
REQ-002 SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream holds a valid payload.
REQ-006 SHALL have port in_ready  output  1  stage accepts the payload this cycle.
REQ-007 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-008 SHALL have port out_valid  output  1  stage presents a valid payload.
REQ-009 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-010 SHALL have port out_data  output  DATA_W  registered payload.
REQ-011 SHALL have port flush  input  1  discard all held payloads (branch/trap kill).
REQ-012 SHALL have port stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-013 SHALL define transfer-in as in_valid&in_ready and transfer-out as out_valid&out_ready, both evaluated at the rising edge.
REQ-014 SHALL drive out_data and out_valid directly from flops; no combinational path from in_data to out_data.
REQ-015 SHALL give a latency of exactly one cycle from transfer-in to out_valid=1 when the stage was empty.
REQ-016 SHALL preserve payload order; no payload duplicated or dropped except by flush or reset.
REQ-017 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-018 SHALL, with flush=1, clear out_valid (and skid entry) at the next edge, ignore any same-cycle transfer-in, and drive in_ready=0 during the flush cycle.
REQ-019 SHALL, when flush and out_ready coincide, count any transfer-out normally but still empty the stage.
REQ-020 SHALL increment stall_cnt by one per cycle with out_valid=1, out_ready=0, saturating at all-ones (no wrap).
REQ-021 SHALL NOT change stall_cnt on flush; only rst clears it.
REQ-022 SHALL accept simultaneous transfer-in and transfer-out in one cycle (full throughput, one payload per cycle).

Reset
REQ-023 SHALL, on rst=1 at an edge, set out_valid=0, skid entry empty, out_data=0, stall_cnt=0.
REQ-024 SHALL drive in_ready=0 while rst=1; reset SHALL take priority over flush and all transfers.
REQ-025 SHALL, on reset mid-stall, discard held payloads; first post-reset in_ready=1 occurs the cycle after rst falls.

Configuration
REQ-026 SHALL use macro PIPE_STAGE_SKID_EN to select skid-buffer mode.
REQ-027 SHALL, with PIPE_STAGE_SKID_EN defined, add one skid entry: in_ready is a flop output equal to "skid entry empty"; a transfer-in while out_valid=1 and out_ready=0 lands in the skid entry; skid drains to out before new input; capacity 2.
REQ-028 SHALL, without PIPE_STAGE_SKID_EN, have capacity 1 and in_ready = ~rst & ~flush & (~out_valid | out_ready) combinationally.

Structure
REQ-029 SHALL place DATA_W/CNT_W defaults and a stage-status enum (EMPTY, FULL, SKID) in shared package pipe_pkg.
REQ-030 SHALL implement the skid state machine EMPTY->FULL (transfer-in), FULL->SKID (transfer-in, no transfer-out), SKID->FULL (transfer-out), FULL->EMPTY (transfer-out, no transfer-in), any->EMPTY (flush/rst).
REQ-031 SHALL factor the saturating counter into sub-module sat_counter (parameter CNT_W, inputs clk, rst, inc).

Verification
REQ-032 SHALL cover: rst=1 two cycles -> out_valid=0, in_ready=0, stall_cnt=0, out_data=0.
REQ-033 SHALL cover: in_valid=1, out_ready=1, in_data=0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later, no bubbles.
REQ-034 SHALL cover: payload 0xA5 held, out_ready=0 for 5 cycles -> out_data=0xA5 stable, stall_cnt=5; with SKID_EN second payload 0x5A accepted then in_ready=0.
REQ-035 SHALL cover: flush=1 with in_valid=1, data 0x77 while full -> next cycle out_valid=0, 0x77 never appears.
REQ-036 SHALL cover: CNT_W=4, 20 stall cycles -> stall_cnt=0xF held.
REQ-037 SHALL cover: random in_valid/out_ready 10k cycles both macro settings -> scoreboard order match, no loss.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_pkg: shared parameter defaults and stage-status encoding for pipe_stage_reg
package pipe_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int CNT_W_DEF  = 16;
   typedef enum logic [1:0] {EMPTY, FULL, SKID} stage_t;
endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter
   import pipe_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);
   always_ff @(posedge clk)
      if (rst) cnt <= '0;
      else if (inc && cnt != '1) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready register slice with flush and stall counter; PIPE_STAGE_SKID_EN adds a skid entry
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   output logic [CNT_W-1:0]  stall_cnt
);
   stage_t            state, state_n;
   logic [DATA_W-1:0] skid_data;
   logic              xin, xout;
   assign xin  = in_valid & in_ready;
   assign xout = out_valid & out_ready;
`ifdef PIPE_STAGE_SKID_EN
   logic rdy_q;
   always_ff @(posedge clk)
      if (rst) rdy_q <= 1'b0;
      else rdy_q <= state_n != SKID;
   assign in_ready = rdy_q & ~rst & ~flush;
`else
   assign in_ready = ~rst & ~flush & (~out_valid | out_ready);
`endif
   // without the skid entry in_ready blocks FULL->SKID, so one FSM serves both builds
   always_comb begin
      state_n = state;
      case (state)
         EMPTY:   if (xin) state_n = FULL;
         FULL:    if (xin && !xout) state_n = SKID;
                  else if (xout && !xin) state_n = EMPTY;
         SKID:    if (xout) state_n = FULL;
         default: state_n = EMPTY;
      endcase
      if (flush) state_n = EMPTY;
   end
   always_ff @(posedge clk)
      if (rst) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         out_data  <= '0;
         skid_data <= '0;
      end else begin
         state     <= state_n;
         out_valid <= state_n != EMPTY;
         if (state == SKID) begin
            if (xout) out_data <= skid_data;
         end else if (xin && (state == EMPTY || xout)) out_data <= in_data;
         if (xin && state == FULL && !xout) skid_data <= in_data;
      end
   sat_counter #(.CNT_W(CNT_W)) u_stall (
      .clk (clk),
      .rst (rst),
      .inc (out_valid & ~out_ready),
      .cnt (stall_cnt)
   );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random scoreboard bench for pipe_stage_reg (either PIPE_STAGE_SKID_EN build)
module tb_pipe_stage_reg;
   localparam int DW = 32;
   localparam int CW = 4;
`ifdef PIPE_STAGE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, out_valid;
   logic [DW-1:0] out_data;
   logic [CW-1:0] stall_cnt;
   int            n_checks = 0, n_fail = 0;
   logic [DW-1:0] q[$];
   int            stall_m = 0;
   bit            prev_rst = 1'b1, started = 1'b0;

   pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
      .in_data (in_data), .out_valid (out_valid), .out_ready (out_ready),
      .out_data (out_data), .flush (flush), .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
      @(negedge clk);
      rst = r; in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
   endtask

   // monitor: samples just before each rising edge, compares against the queue model, then advances it
   always begin
      bit exp_rdy;
      @(negedge clk);
      #4;
      exp_rdy = !rst && !flush && ((CAP == 2) ? (!prev_rst && q.size() < 2)
                                              : (q.size() == 0 || out_ready));
      if (started) begin
         chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
         if (q.size() != 0) chk("out_data", out_data, q[0]);
         chk("stall_cnt", {28'b0, stall_cnt}, stall_m);
         chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
      end
      if (rst) begin
         q.delete();
         stall_m  = 0;
         prev_rst = 1'b1;
         started  = 1'b1;
      end else begin
         if (q.size() != 0 && !out_ready && stall_m < 15) stall_m++;
         if (q.size() != 0 && out_ready) void'(q.pop_front());
         if (flush) q.delete();
         else if (in_valid && exp_rdy) q.push_back(in_data);
         prev_rst = 1'b0;
      end
   end

   task automatic do_reset();
      drive(1, 0, '0, 0, 0);
      drive(1, 0, '0, 0, 0);
      drive(0, 0, '0, 0, 0);
      drive(0, 0, '0, 0, 0);
   endtask

   initial begin
      // reset held two cycles
      drive(1, 0, '0, 0, 0);
      drive(1, 0, '0, 0, 0);
      @(posedge clk); #1;
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_in_ready", {31'b0, in_ready}, 0);
      chk("rst_stall_cnt", {28'b0, stall_cnt}, 0);
      chk("rst_out_data", out_data, 0);
      drive(0, 0, '0, 0, 0);
      drive(0, 0, '0, 0, 0);
      // back-to-back stream, no bubbles
      drive(0, 1, 32'h1, 1, 0);
      drive(0, 1, 32'h2, 1, 0);
      #1 chk("bb_data1", out_data, 32'h1);
      chk("bb_valid1", {31'b0, out_valid}, 1);
      drive(0, 1, 32'h3, 1, 0);
      #1 chk("bb_data2", out_data, 32'h2);
      drive(0, 0, '0, 1, 0);
      #1 chk("bb_data3", out_data, 32'h3);
      chk("bb_valid3", {31'b0, out_valid}, 1);
      drive(0, 0, '0, 1, 0);
      // hold under backpressure for five cycles
      do_reset();
      drive(0, 1, 32'hA5, 0, 0);
      drive(0, 1, 32'h5A, 0, 0);
      repeat (4) drive(0, 0, '0, 0, 0);
      @(posedge clk); #1;
      chk("hold_data", out_data, 32'hA5);
      chk("hold_stall", {28'b0, stall_cnt}, 5);
      chk("hold_in_ready", {31'b0, in_ready}, 0);
      repeat (3) drive(0, 0, '0, 1, 0);
      // flush while full discards held data and the same-cycle input
      drive(0, 1, 32'h11, 0, 0);
      drive(0, 1, 32'h77, 0, 1);
      #1 chk("flush_in_ready", {31'b0, in_ready}, 0);
      @(posedge clk); #1;
      chk("flush_out_valid", {31'b0, out_valid}, 0);
      repeat (3) drive(0, 0, '0, 1, 0);
      // stall counter saturation
      do_reset();
      drive(0, 1, 32'hC3, 0, 0);
      repeat (20) drive(0, 0, '0, 0, 0);
      @(posedge clk); #1;
      chk("sat_15", {28'b0, stall_cnt}, 15);
      drive(0, 0, '0, 0, 1);
      @(posedge clk); #1;
      chk("sat_after_flush", {28'b0, stall_cnt}, 15);
      drive(0, 0, '0, 1, 0);
      // random traffic
      for (int i = 0; i < 10000; i++)
         drive($urandom_range(0, 499) == 0, $urandom_range(0, 2) != 0, $urandom,
               $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
      repeat (8) drive(0, 0, '0, 1, 0);
      @(negedge clk); #6;
      chk("drain_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
